serial_adder8: RTL and testbench
================================

SERIAL_ADDER8 -- requirements
Module: serial_adder8

Interface
REQ-001 The module SHALL have the port `clk`, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-002 The module SHALL have the port `reset`, input, 1 bit: synchronous, active-high reset.
REQ-003 The module SHALL have the port `Start`, input, 1 bit: request to begin an addition, sampled only in IDLE.
REQ-004 The module SHALL have the port `AddX`, input, 8 bits: first operand, captured on the accepted Start edge.
REQ-005 The module SHALL have the port `AddY`, input, 8 bits: second operand, captured on the accepted Start edge.
REQ-006 The module SHALL have the port `CarryIn`, input, 1 bit: carry into bit 0, captured on the accepted Start edge.
REQ-007 The module SHALL have the port `Sum`, output, 8 bits: registered result, i.e. (AddX + AddY + CarryIn) mod 256.
REQ-008 The module SHALL have the port `CarryOut`, output, 1 bit: registered carry out of bit 7.
REQ-009 The module SHALL have the port `Busy`, output, 1 bit: high while bits are being processed (RUN state).
REQ-010 The module SHALL have the port `Done`, output, 1 bit: one-cycle pulse when Sum/CarryOut hold a new result.

Function
REQ-011 The block SHALL be a bit-serial adder that computes the same result as an 8-bit ripple adder, using one full-adder cell and one carry flip-flop.
REQ-012 The FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-013 IDLE with Start=1 at an edge SHALL load AddX, AddY and CarryIn into internal shift/carry registers, clear the bit counter to 0 and go to RUN.
REQ-014 IDLE with Start=0 SHALL remain in IDLE and leave all outputs unchanged.
REQ-015 At each RUN edge, the block SHALL compute bit[k] = x0 ^ y0 ^ c and new c = majority(x0, y0, c).
  - x0 and y0 are the operand register LSBs.
  - Each operand register SHALL shift right by one.
  - The sum bit SHALL shift into the MSB of an internal result register.
  - The counter SHALL increment.
REQ-016 The 3-bit counter SHALL run 0..7; the RUN edge with counter==7 processes bit 7, then:
  - Sum SHALL be updated from the completed internal result.
  - CarryOut SHALL be updated from the new carry.
  - The FSM SHALL go to DONE.
REQ-017 DONE SHALL last exactly one cycle, with Done=1 during it, and then return unconditionally to IDLE.
REQ-018 Start asserted in DONE SHALL be ignored.
REQ-019 Busy SHALL equal 1 only in RUN, and Done SHALL equal 1 only in DONE; the two are never both high.
REQ-020 Latency: Start is accepted at edge E; Busy is high after edges E..E+7; Done is high in the cycle after edge E+8.
REQ-021 Throughput SHALL be one addition per 10 cycles when Start is held high continuously.
REQ-022 Start, AddX, AddY and CarryIn SHALL be ignored while in RUN; operand changes mid-operation SHALL NOT affect the result.
REQ-023 Sum and CarryOut SHALL change only at the DONE-entry edge or on reset, and SHALL hold the last result otherwise.
REQ-024 Overflow SHALL wrap modulo 256, with the 9th bit reported only on CarryOut.
REQ-025 The block SHALL use no combinational path from any input to any output; all outputs are registered or decoded from state.

Reset
REQ-026 With reset=1 at an edge, the block SHALL go to IDLE and clear Sum, CarryOut, the counter, the carry register, the operand registers and the internal result to 0.
REQ-027 During reset, Busy=0 and Done=0.
REQ-028 Reset SHALL take priority over Start and over RUN/DONE progress.
REQ-029 Reset mid-RUN SHALL abort the operation: no Done pulse, and Sum/CarryOut = 0.
REQ-030 After reset deasserts, the first Start SHALL be accepted at the next edge with normal latency.

Verification
REQ-031 The bench SHALL cover: AddX=0x5A, AddY=0x3C, CarryIn=0, Start one cycle -> Done 9 edges later; Sum=0x96, CarryOut=0; Busy high for exactly 8 cycles.
REQ-032 The bench SHALL cover: AddX=0xFF, AddY=0x01, CarryIn=0 -> Sum=0x00, CarryOut=1 (wrap).
REQ-033 The bench SHALL cover: AddX=0xFF, AddY=0xFF, CarryIn=1 -> Sum=0xFF, CarryOut=1; AddX=0x00, AddY=0x00, CarryIn=1 -> Sum=0x01, CarryOut=0.
REQ-034 The bench SHALL cover Start pulsed with AddX changed to 0x00 during RUN of a 0x10+0x20 operation:
  - Result Sum=0x30.
  - The extra Start is ignored.
  - Exactly one Done pulse.
REQ-035 The bench SHALL cover: complete 0x12+0x34 (Sum=0x46), then start 0x80+0x80 and assert reset on the 4th RUN cycle -> no Done; Sum=0x00, CarryOut=0, Busy=0; the next Start 0x01+0x02 -> Sum=0x03.
REQ-036 The bench SHALL cover Start held high continuously over 3 additions -> Done pulses 10 cycles apart; Start in DONE ignored; each result equals the reference-model sum.

Source files
------------

// File: rtl/serial_adder8.sv
// Bit-serial 8-bit adder: one full-adder cell and one carry flop process an
// operand pair LSB-first over eight RUN cycles, then present Sum/CarryOut for one Done cycle.
//
// state | meaning
// IDLE  | waiting for Start; operands are captured on the accepting edge
// RUN   | one bit per edge, bit_cnt 0..7
// DONE  | one-cycle Done pulse, returns to IDLE regardless of Start
module serial_adder8 (
    input  logic       clk,
    input  logic       reset,
    input  logic       Start,
    input  logic [7:0] AddX,
    input  logic [7:0] AddY,
    input  logic       CarryIn,
    output logic [7:0] Sum,
    output logic       CarryOut,
    output logic       Busy,
    output logic       Done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [7:0] x_reg;
    logic [7:0] y_reg;
    logic [7:0] res_reg;
    logic       carry;
    logic [2:0] bit_cnt;
    logic       sum_bit;
    logic       carry_next;

    assign sum_bit    = x_reg[0] ^ y_reg[0] ^ carry;
    assign carry_next = (x_reg[0] & y_reg[0]) | (x_reg[0] & carry) | (y_reg[0] & carry);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (Start) state_next = RUN;
            RUN:     if (bit_cnt == 3'd7) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        Busy = (state == RUN);
        Done = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            x_reg    <= '0;
            y_reg    <= '0;
            res_reg  <= '0;
            carry    <= 1'b0;
            bit_cnt  <= '0;
            Sum      <= '0;
            CarryOut <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (Start) begin
                        x_reg   <= AddX;
                        y_reg   <= AddY;
                        carry   <= CarryIn;
                        bit_cnt <= '0;
                    end
                end
                RUN: begin
                    x_reg   <= {1'b0, x_reg[7:1]};
                    y_reg   <= {1'b0, y_reg[7:1]};
                    res_reg <= {sum_bit, res_reg[7:1]};
                    carry   <= carry_next;
                    bit_cnt <= bit_cnt + 3'd1;
                    // The last bit lands straight in Sum; res_reg is only complete one edge later.
                    if (bit_cnt == 3'd7) begin
                        Sum      <= {sum_bit, res_reg[7:1]};
                        CarryOut <= carry_next;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder8.sv
// Directed bench for serial_adder8: latency, wrap, mid-run operand changes,
// abort by reset and back-to-back operation with Start held high.
module tb_serial_adder8;

    logic       clk = 1'b0;
    logic       reset;
    logic       Start;
    logic [7:0] AddX;
    logic [7:0] AddY;
    logic       CarryIn;
    logic [7:0] Sum;
    logic       CarryOut;
    logic       Busy;
    logic       Done;

    int checks = 0;
    int errors = 0;

    serial_adder8 dut (
        .clk      (clk),
        .reset    (reset),
        .Start    (Start),
        .AddX     (AddX),
        .AddY     (AddY),
        .CarryIn  (CarryIn),
        .Sum      (Sum),
        .CarryOut (CarryOut),
        .Busy     (Busy),
        .Done     (Done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [8:0] observed, input logic [8:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [8:0] model(input logic [7:0] x, input logic [7:0] y, input logic ci);
        return {1'b0, x} + {1'b0, y} + {8'd0, ci};
    endfunction

    // One Start pulse, then exact cycle-by-cycle checks of Busy/Done and the result.
    task automatic run_add(input string tag, input logic [7:0] x, input logic [7:0] y,
                           input logic ci, input logic [7:0] exp_sum, input logic exp_co);
        check({tag, " idle_busy"}, {8'd0, Busy}, 9'd0);
        Start = 1'b1; AddX = x; AddY = y; CarryIn = ci;
        tick();
        Start = 1'b0; AddX = 8'hA5; AddY = 8'h5A; CarryIn = ~ci;
        for (int i = 0; i < 8; i++) begin
            check({tag, " busy"}, {7'd0, Busy, Done}, 9'b0_0000_0010);
            if (i < 7) tick();
        end
        tick();
        check({tag, " done"}, {7'd0, Busy, Done}, 9'b0_0000_0001);
        check({tag, " result"}, {CarryOut, Sum}, {exp_co, exp_sum});
        tick();
        check({tag, " after_done"}, {7'd0, Busy, Done}, 9'd0);
        check({tag, " hold"}, {CarryOut, Sum}, {exp_co, exp_sum});
    endtask

    initial begin
        int         done_cnt;
        int         prev_done;
        logic       last_done;
        logic [7:0] ops_x [3];
        logic [7:0] ops_y [3];
        logic       ops_c [3];

        reset = 1'b1; Start = 1'b1; AddX = 8'hFF; AddY = 8'hFF; CarryIn = 1'b1;
        tick();
        tick();
        check("reset_outputs", {CarryOut, Sum}, 9'd0);
        check("reset_flags", {7'd0, Busy, Done}, 9'd0);
        reset = 1'b0; Start = 1'b0;
        tick();
        check("idle_no_start", {7'd0, Busy, Done}, 9'd0);

        run_add("a5a_3c", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0);
        run_add("wrap_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
        run_add("ff_ff_c1", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
        run_add("00_00_c1", 8'h00, 8'h00, 1'b1, 8'h01, 1'b0);

        // Operand change and extra Start during RUN must be ignored.
        Start = 1'b1; AddX = 8'h10; AddY = 8'h20; CarryIn = 1'b0;
        tick();
        Start = 1'b0;
        tick();
        tick();
        AddX = 8'h00; Start = 1'b1;
        tick();
        Start = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (Done) done_cnt++;
        end
        check("midrun_done_count", 9'(done_cnt), 9'd1);
        check("midrun_result", {CarryOut, Sum}, 9'h030);

        // Abort by reset on the 4th RUN cycle.
        run_add("12_34", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0);
        Start = 1'b1; AddX = 8'h80; AddY = 8'h80; CarryIn = 1'b0;
        tick();
        Start = 1'b0;
        tick();
        tick();
        tick();
        check("abort_busy_before", {7'd0, Busy, Done}, 9'b0_0000_0010);
        reset = 1'b1;
        tick();
        check("abort_flags", {7'd0, Busy, Done}, 9'd0);
        check("abort_result", {CarryOut, Sum}, 9'd0);
        reset = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (Done) done_cnt++;
        end
        check("abort_no_done", 9'(done_cnt), 9'd0);
        check("abort_result_hold", {CarryOut, Sum}, 9'd0);
        run_add("after_abort", 8'h01, 8'h02, 1'b0, 8'h03, 1'b0);

        // Start held high: three additions, Done every 10 cycles.
        ops_x = '{8'hC3, 8'h7F, 8'h0F};
        ops_y = '{8'h4E, 8'h80, 8'hF1};
        ops_c = '{1'b1, 1'b1, 1'b0};
        done_cnt  = 0;
        prev_done = -1;
        last_done = 1'b0;
        Start = 1'b1; AddX = ops_x[0]; AddY = ops_y[0]; CarryIn = ops_c[0];
        for (int i = 0; i < 35; i++) begin
            tick();
            if (last_done) check("cont_done_ignores_start", {7'd0, Busy, Done}, 9'd0);
            last_done = Done;
            if (Done) begin
                if (done_cnt < 3)
                    check("cont_result", {CarryOut, Sum},
                          model(ops_x[done_cnt], ops_y[done_cnt], ops_c[done_cnt]));
                if (prev_done >= 0) check("cont_spacing", 9'(i - prev_done), 9'd10);
                prev_done = i;
                done_cnt++;
                if (done_cnt < 3) begin
                    AddX = ops_x[done_cnt]; AddY = ops_y[done_cnt]; CarryIn = ops_c[done_cnt];
                end else begin
                    Start = 1'b0;
                end
            end else if (Busy) begin
                AddX = ~AddX; AddY = ~AddY;
                if (done_cnt < 3) begin
                    AddX = ops_x[done_cnt] ^ 8'h3C; AddY = ops_y[done_cnt] ^ 8'hC3;
                end
            end
            if (!Busy && !Done && done_cnt < 3) begin
                AddX = ops_x[done_cnt]; AddY = ops_y[done_cnt]; CarryIn = ops_c[done_cnt];
            end
        end
        check("cont_done_count", 9'(done_cnt), 9'd3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
